// File: rtl/fir_result_reader.sv
// Streams a block of FIR results out of a registered-read memory through a 2-entry FIFO.
// Define FIR_RDR_CHECKSUM_EN to enable the running 16-bit checksum of streamed samples.
module fir_result_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_left_q, rd_left_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        credit;

    always_comb begin
        pop    = (occ_q != 2'd0) && m_ready;
        push   = pend_q;
        // A read is only issued if its data is guaranteed a FIFO slot on arrival.
        credit = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
        issue  = (state_q == READ) && (credit < 3'd2);

        state_d     = state_q;
        addr_d      = addr_q;
        rd_left_d   = rd_left_q;
        pend_d      = issue;
        pend_last_d = issue && (rd_left_q == ADDR_W'(1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = base_addr;
                    rd_left_d = count;
                    state_d   = (count == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - ADDR_W'(1);
                    if (rd_left_q == ADDR_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last0_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        occ_d   = occ_q;
        // Entry 0 is always the head; a pop shifts entry 1 forward.
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    data0_d = mem_rdata;
                    last0_d = pend_last_q;
                end else begin
                    data1_d = mem_rdata;
                    last1_d = pend_last_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = mem_rdata;
                    last0_d = pend_last_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = mem_rdata;
                    last1_d = pend_last_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_left_q   <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            occ_q       <= 2'd0;
            data0_q     <= '0;
            data1_q     <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            occ_q       <= occ_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

    assign mem_re   = issue;
    assign mem_addr = addr_q;
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = data0_q;
    assign m_last   = last0_q && (occ_q != 2'd0);
    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign done     = (state_q == FIN);

`ifdef FIR_RDR_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = 16'd0;
        end else if (pop) begin
            checksum_d = checksum_q + 16'($signed(data0_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= 16'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_fir_result_reader.sv
// Self-checking bench for fir_result_reader: a memory model plus scoreboard queues of
// expected addresses, samples and last flags filled when each job is started.
module tb_fir_result_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  base_addr;
   logic [9:0]  count;
   logic        mem_re;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_rdata;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;
   logic        busy;
   logic        done;
   logic [15:0] checksum;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int beats = 0;
   int doneCount = 0;
   int doneCyc = -1;
   int firstRe = -1;
   int firstValid = -1;
   int lastBeat = -1;
   bit monEn = 0;
   bit stallPrev = 0;
   logic [7:0] prevData;
   logic       prevLast;

   logic [7:0] mem [1024];
   logic [7:0] expData [$];
   bit         expLast [$];
   int         expAddr [$];

   fir_result_reader #(.ADDR_W(10), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   // Free-running clock and cycle counter used for latency checks
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered-read memory: data appears the cycle after mem_re
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ctrl"}, {m_valid, m_last, mem_re, busy, done}, 5'b0);
      checkOutput({tag, "_m_data"}, m_data, 0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 0);
      checkOutput({tag, "_checksum"}, checksum, 0);
   endtask

   function automatic logic readyFor(input int mode, input int c);
      if (mode == 0) return 1'b1;
      return (c % 4 == 0) || (c % 4 == 3);
   endfunction

   // Monitor: compares every read address and every handshake against the scoreboard,
   // and checks that a stalled beat holds still until it is accepted
   always @(negedge clk) begin
      if (monEn && rst_n) begin
         if (mem_re) begin
            if (firstRe < 0) firstRe = cyc;
            if (expAddr.size() == 0) checkOutput("spurious_mem_re", mem_re, 0);
            else checkOutput("mem_addr", mem_addr, expAddr.pop_front());
         end
         if (stallPrev) begin
            checkOutput("hold_valid", m_valid, 1);
            checkOutput("hold_data", m_data, prevData);
            checkOutput("hold_last", m_last, prevLast);
         end
         if (m_valid) begin
            if (firstValid < 0) firstValid = cyc;
            if (expData.size() == 0) checkOutput("spurious_m_valid", m_valid, 0);
            else if (m_ready) begin
               checkOutput("m_data", m_data, expData.pop_front());
               checkOutput("m_last", m_last, expLast.pop_front());
               beats++;
               lastBeat = cyc;
            end
         end
         stallPrev = m_valid && !m_ready;
         prevData = m_data;
         prevLast = m_last;
         if (done) begin
            doneCount++;
            doneCyc = cyc;
            checkOutput("busy_at_done", busy, 0);
         end
      end else begin
         stallPrev = 0;
      end
   end

   // Runs one job; restartBeat pulses start mid-job, resetBeat asserts reset mid-job
   task automatic applyStimulus(input int base, input int cnt, input int mode,
                                input int restartBeat, input int resetBeat);
      int s;
      int expSum;
      int idx;
      bit restarted;
      logic [15:0] expCk;
      expSum = 0;
      restarted = 0;
      for (int i = 0; i < cnt; i++) begin
         idx = (base + i) % 1024;
         expData.push_back(mem[idx]);
         expLast.push_back(i == cnt - 1);
         expAddr.push_back(idx);
         expSum += int'($signed(mem[idx]));
      end
`ifdef FIR_RDR_CHECKSUM_EN
      expCk = expSum[15:0];
`else
      expCk = 16'd0;
`endif
      beats = 0; doneCount = 0; doneCyc = -1;
      firstRe = -1; firstValid = -1; lastBeat = -1;

      @(posedge clk); #1;
      start = 1; base_addr = 10'(base); count = 10'(cnt);
      m_ready = readyFor(mode, cyc);
      s = cyc;
      for (int t = 0; t < 400; t++) begin
         @(posedge clk); #1;
         if (doneCount > 0) break;
         if (t == 0 && cnt > 0) checkOutput("busy_in_job", busy, 1);
         if (resetBeat >= 0 && beats >= resetBeat) begin
            checkOutput("beats_before_rst", beats, resetBeat);
            rst_n = 0; monEn = 0; start = 0;
            @(posedge clk); #1;
            rst_n = 1;
            @(negedge clk);
            checkResetOutputs("rst_mid");
            expData.delete(); expLast.delete(); expAddr.delete();
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               checkOutput("no_done_after_rst", done, 0);
            end
            monEn = 1;
            return;
         end
         if (restartBeat >= 0 && beats >= restartBeat && !restarted) begin
            start = 1; base_addr = 10'd500; count = 10'd3;
            restarted = 1;
         end else begin
            start = 0;
         end
         m_ready = readyFor(mode, cyc);
         @(negedge clk);
      end
      start = 0;
      checkOutput("done_count", doneCount, 1);
      checkOutput("beat_count", beats, cnt);
      checkOutput("scoreboard_empty", expData.size() + expAddr.size(), 0);
      checkOutput("checksum", checksum, expCk);
      if (cnt == 0) begin
         checkOutput("zero_done_latency", doneCyc - s, 1);
         checkOutput("zero_no_mem_re", firstRe, -1);
         checkOutput("zero_no_valid", firstValid, -1);
      end else if (mode == 0) begin
         checkOutput("first_re_latency", firstRe - s, 1);
         checkOutput("first_valid_latency", firstValid - s, 3);
         checkOutput("back_to_back", lastBeat - firstValid, cnt - 1);
         checkOutput("done_after_last", doneCyc - lastBeat, 1);
      end
   endtask

   initial begin
      rst_n = 0; start = 0; base_addr = 0; count = 0; m_ready = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      for (int i = 0; i < 20; i++) mem[32 + i] = 8'(i + 1);
      mem[1022] = 8'hFD;
      mem[1023] = 8'hFE;
      mem[0]    = 8'hFF;
      mem[1]    = 8'h05;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("rst_init");
      @(posedge clk); #1;
      rst_n = 1; monEn = 1;

      $display("[TB] job base=32 count=20 ready=1");
      applyStimulus(32, 20, 0, -1, -1);
      $display("[TB] job base=32 count=20 ready pattern 1,0,0,1");
      applyStimulus(32, 20, 1, -1, -1);
      $display("[TB] job base=1022 count=4 address wrap");
      applyStimulus(1022, 4, 0, -1, -1);
      $display("[TB] job count=0");
      applyStimulus(0, 0, 0, -1, -1);
      $display("[TB] job count=20 with start pulsed mid-job");
      applyStimulus(32, 20, 0, 8, -1);
      $display("[TB] job count=20 with reset after beat 5");
      applyStimulus(32, 20, 0, -1, 5);
      $display("[TB] job count=20 after reset");
      applyStimulus(32, 20, 0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
